// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the configurable serial pattern detector.
package seq_det_pkg;

    localparam logic [7:0]  DEF_PAT = 8'h0B;
    localparam int unsigned DEF_LEN = 4;
    localparam bit          DEF_OVL = 1'b1;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction

    // Lengths outside 1..max_len are pulled to the nearest legal value.
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
        if (len == 0)       return 1;
        if (len > max_len)  return max_len;
        return len;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; clear wins over hold but a same-cycle increment still counts once.
module sat_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] q
);

    logic [CNT_W-1:0] r_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= inc ? CNT_W'(1) : '0;
        end else if (inc && (r_q != '1)) begin
            r_q <= r_q + CNT_W'(1);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/seq_detector_cfg.sv
// Runtime-programmable serial pattern detector with Mealy and Moore match flags
// and a saturating match counter.
module seq_detector_cfg
    import seq_det_pkg::*;
#(
    parameter int unsigned      PAT_W       = 8,
    parameter int unsigned      CNT_W       = 8,
    parameter logic [PAT_W-1:0] PAT_DEFAULT = PAT_W'(DEF_PAT),
    parameter int unsigned      LEN_DEFAULT = DEF_LEN,
    parameter bit               OVL_DEFAULT = DEF_OVL,
    localparam int unsigned     LW          = clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pat,
    input  logic [LW-1:0]    cfg_len,
    input  logic             cfg_overlap,
    input  logic             cnt_clr,
    output logic             mealy_flag,
    output logic             moore_flag,
    output logic [CNT_W-1:0] match_cnt
);

    localparam logic [LW-1:0] LEN_RST  = LW'(clamp_len(LEN_DEFAULT, PAT_W));
    localparam logic [LW-1:0] FILL_MAX = LW'(PAT_W);

    // Newest bit in the LSB; the oldest history bit is never compared, so only PAT_W-1 are kept.
    logic [PAT_W-2:0] r_hist;
    logic [PAT_W-1:0] r_pat;
    logic [LW-1:0]    r_len;
    logic [LW-1:0]    r_fill;
    logic             r_ovl;
    logic             r_moore;

    logic [PAT_W-1:0] w_nxt;
    logic [PAT_W-1:0] w_mask;
    logic             w_accept;
    logic             w_filled;
    logic             w_match;

    always_comb begin
        w_accept = din_valid & ~cfg_we;
        w_nxt    = {r_hist, din};
        w_mask   = ~({PAT_W{1'b1}} << r_len);
        w_filled = ({1'b0, r_fill} + (LW + 1)'(1)) >= {1'b0, r_len};
        w_match  = rst & w_accept & w_filled & (((w_nxt ^ r_pat) & w_mask) == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hist  <= '0;
            r_fill  <= '0;
            r_pat   <= PAT_DEFAULT;
            r_len   <= LEN_RST;
            r_ovl   <= OVL_DEFAULT;
            r_moore <= 1'b0;
        end else begin
            r_moore <= w_match;
            if (cfg_we) begin
                r_pat  <= cfg_pat;
                r_len  <= LW'(clamp_len(32'(cfg_len), PAT_W));
                r_ovl  <= cfg_overlap;
                r_hist <= '0;
                r_fill <= '0;
            end else if (din_valid) begin
                r_hist <= w_nxt[PAT_W-2:0];
                if (w_match && !r_ovl) begin
                    r_fill <= '0;
                end else if (r_fill != FILL_MAX) begin
                    r_fill <= r_fill + LW'(1);
                end
            end
        end
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clk(clk),
        .rst(rst),
        .inc(w_match),
        .clr(cnt_clr | cfg_we),
        .q  (match_cnt)
    );

    assign mealy_flag = w_match;
    assign moore_flag = r_moore;

endmodule

// File: tb/tb_seq_detector_cfg.sv
// Scoreboard bench for seq_detector_cfg: directed scenarios then random traffic,
// checked against a bit-queue reference model.
module tb_seq_detector_cfg;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       din = 1'b0;
    logic       din_valid = 1'b0;
    logic       cfg_we = 1'b0;
    logic [7:0] cfg_pat = '0;
    logic [3:0] cfg_len = '0;
    logic       cfg_overlap = 1'b0;
    logic       cnt_clr = 1'b0;

    logic       mealy_a, moore_a, mealy_b, moore_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;

    always #5 clk = ~clk;

    seq_detector_cfg #(.PAT_W(8), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .cfg_we(cfg_we),
        .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
        .mealy_flag(mealy_a), .moore_flag(moore_a), .match_cnt(cnt_a)
    );

    seq_detector_cfg #(.PAT_W(8), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .cfg_we(cfg_we),
        .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
        .mealy_flag(mealy_b), .moore_flag(moore_b), .match_cnt(cnt_b)
    );

    typedef struct packed {
        logic       mealy;
        logic       moore;
        logic [7:0] c8;
        logic [1:0] c2;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: the accepted bits since the last clear, oldest first.
    bit         m_bits[$];
    logic [7:0] m_pat;
    int         m_len;
    bit         m_ovl;
    int         m_cnt8, m_cnt2;
    bit         m_prev;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_bits.delete();
        m_pat  = 8'h0B;
        m_len  = 4;
        m_ovl  = 1'b1;
        m_cnt8 = 0;
        m_cnt2 = 0;
        m_prev = 1'b0;
    endtask

    task automatic push_zero();
        exp_t e;
        e = '0;
        sb.push_back(e);
    endtask

    task automatic eval_push();
        bit   cand[$];
        bit   mealy;
        exp_t e;
        mealy = 1'b0;
        if (din_valid && !cfg_we) begin
            cand = m_bits;
            cand.push_back(din);
            if (cand.size() >= m_len) begin
                mealy = 1'b1;
                for (int k = 0; k < m_len; k++)
                    if (cand[cand.size() - 1 - k] != m_pat[k]) mealy = 1'b0;
            end
        end
        e.mealy = mealy;
        e.moore = m_prev;
        e.c8    = 8'(m_cnt8);
        e.c2    = 2'(m_cnt2);
        sb.push_back(e);
        if (cfg_we) begin
            m_bits.delete();
            m_pat  = cfg_pat;
            m_len  = (cfg_len == 0) ? 1 : ((cfg_len > 8) ? 8 : int'(cfg_len));
            m_ovl  = cfg_overlap;
            m_cnt8 = 0;
            m_cnt2 = 0;
        end else begin
            if (din_valid) begin
                if (mealy && !m_ovl) m_bits.delete();
                else begin
                    m_bits.push_back(din);
                    if (m_bits.size() > 8) void'(m_bits.pop_front());
                end
            end
            if (cnt_clr) begin
                m_cnt8 = mealy ? 1 : 0;
                m_cnt2 = mealy ? 1 : 0;
            end else if (mealy) begin
                if (m_cnt8 < 255) m_cnt8++;
                if (m_cnt2 < 3)   m_cnt2++;
            end
        end
        m_prev = mealy;
    endtask

    task automatic step(input logic d, input logic v, input logic we, input logic [7:0] p,
                        input logic [3:0] l, input logic o, input logic c);
        @(posedge clk); #1;
        din = d; din_valid = v; cfg_we = we; cfg_pat = p; cfg_len = l;
        cfg_overlap = o; cnt_clr = c;
        eval_push();
    endtask

    task automatic bit_in(input logic d);
        step(d, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic o);
        step(1'b0, 1'b1, 1'b1, p, l, o, 1'b0);
    endtask

    task automatic bits_in(input logic [7:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) bit_in(v[i]);
    endtask

    // Monitor: outputs are presented every cycle; compare each one at the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                chk("mealy_flag", 32'(mealy_a), 32'(e.mealy));
                chk("moore_flag", 32'(moore_a), 32'(e.moore));
                chk("match_cnt",  32'(cnt_a),   32'(e.c8));
                chk("mealy_flag_w2", 32'(mealy_b), 32'(e.mealy));
                chk("match_cnt_w2",  32'(cnt_b),   32'(e.c2));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        model_reset();
        @(posedge clk); #1;
        push_zero();
        @(posedge clk); #1;
        rst = 1'b1;
        eval_push();

        // 1: overlapping matches on bits 4 and 7
        bits_in(8'b0101_1011, 7);
        idle();
        // 2: non-overlap, same stream
        cfg(8'h0B, 4'd4, 1'b0);
        bits_in(8'b0101_1011, 7);
        idle();
        // 3: valid gaps are ignored
        cfg(8'h0B, 4'd4, 1'b1);
        bit_in(1'b1); bit_in(1'b0);
        idle(); idle(); idle();
        bit_in(1'b1); bit_in(1'b1);
        idle();
        // 4: reconfigure with bits in flight
        bits_in(8'b0000_0101, 3);
        cfg(8'hF0, 4'd8, 1'b1);
        bits_in(8'hF0, 8);
        idle();
        // 5: counter saturation on the 2-bit instance, then clear with a match
        cfg(8'h0B, 4'd4, 1'b0);
        for (int r = 0; r < 5; r++) bits_in(8'h0B, 4);
        bits_in(8'b0000_0101, 3);
        step(1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1);
        idle();
        // length clamp edges
        cfg(8'hFF, 4'd0, 1'b1);
        bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
        cfg(8'hAA, 4'd15, 1'b1);
        bits_in(8'hAA, 8); bit_in(1'b1); bit_in(1'b0);
        // 6: asynchronous reset mid-pattern
        cfg(8'h0B, 4'd4, 1'b1);
        bits_in(8'b0000_0101, 3);
        @(posedge clk); #1;
        din = 1'b1; din_valid = 1'b1; cfg_we = 1'b0; cnt_clr = 1'b0;
        #2 rst = 1'b0;
        model_reset();
        push_zero();
        @(posedge clk); #1;
        din_valid = 1'b0;
        push_zero();
        @(posedge clk); #1;
        rst = 1'b1;
        eval_push();
        bit_in(1'b1);
        idle();
        bits_in(8'h0B, 4);
        idle();

        // random traffic
        for (int i = 0; i < 800; i++) begin
            logic [3:0] l;
            l = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 4));
            step(1'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0,
                 8'($urandom), l, 1'($urandom), $urandom_range(0, 30) == 0);
        end
        idle();

        @(posedge clk);
        @(negedge clk); #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
